link_master: RTL and testbench
==============================

Name: link_master

Overview:
- Transmit side of the byte-wide 4-phase req/ack link; drives the link receiver directly.
- Collects a burst of NUM_BYTES bytes from an upstream valid/ready source into a local buffer.
- Sends each byte with a full 4-phase handshake (req↑, ack↑, req↓, ack↓).
- Reports burst completion or an ack timeout.

Parameters:
- NUM_BYTES, 4, bytes per burst; must be ≥2.
- TIMEOUT_CYCLES, 15, maximum cycles spent waiting for an ack edge before aborting; must be ≥4.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream byte valid
- in_data  input  8  upstream byte
- in_ready  output  1  master accepts a byte this cycle
- req  output  1  link request to receiver
- ack  input  1  link acknowledge from receiver
- data  output  8  link data; stable while a byte is in flight
- busy  output  1  burst transmission in progress
- done  output  1  one-cycle pulse: burst sent successfully
- err  output  1  one-cycle pulse: ack timeout, burst aborted

Behaviour:
- Reset is clk, rst: synchronous, active-high.
  - State goes to FILL; wr_idx, tx_idx and timeout counter clear to 0.
  - Outputs after reset: req=0, done=0, err=0, busy=0, data=0, in_ready=1.
  - Buffer contents are not reset.
- Moore machine: every output decodes from registered state/indices only. No combinational path from ack or in_valid to any output.
- FILL:
  - in_ready=1.
  - On in_valid&&in_ready: buf[wr_idx] <= in_data, wr_idx++.
  - Accepting the byte at wr_idx==NUM_BYTES-1 goes to SEND_REQ with tx_idx=0, wr_idx=0.
- SEND_REQ:
  - req=1, busy=1, data=buf[tx_idx].
  - ack==1 goes to WAIT_ACK_LOW.
- WAIT_ACK_LOW:
  - req=0, busy=1, data held at buf[tx_idx].
  - On ack==0: if tx_idx==NUM_BYTES-1 go to DONE; else tx_idx++ and go to SEND_REQ.
- DONE: done=1 for exactly one cycle, then FILL.
- ERROR: err=1 for exactly one cycle, req=0, then FILL with wr_idx=0.
- in_ready=0 in every state except FILL. Bytes offered outside FILL are not accepted.
- data is 0 in FILL, DONE and ERROR.
- Timeout counter:
  - Clears on every entry into SEND_REQ or WAIT_ACK_LOW.
  - Increments each cycle in those states while the exit condition is false.
  - When it reaches TIMEOUT_CYCLES with the condition still false, go to ERROR.
  - Width is $clog2(TIMEOUT_CYCLES+1).
- Timing with the standard receiver (ack rises 1 cycle after sampling req, drops combinationally once req is low in its wait-drop state):
  - Each byte takes 4 cycles.
  - A burst takes 4*NUM_BYTES cycles from the first SEND_REQ to done.
  - The receiver samples data on the 2nd edge after req rises; data is held well past that edge.
- Simultaneous events:
  - ack rising on the same cycle the timeout counter hits its limit: the ack wins, so the transition proceeds and there is no err.
  - ack already low on entry to WAIT_ACK_LOW: leave on the next edge.
- rst mid-burst: req drops at the next edge and the partial burst is discarded. No done and no err are generated.
- Indices wrap only by explicit clear, never by overflow.

Decomposition:
- Package link_pkg holds:
  - the master state enum: FILL, SEND_REQ, WAIT_ACK_LOW, DONE, ERROR;
  - the link data width localparam (8);
  - the default burst length (4), shared with the receiver.
- One sub-module, link_timeout: a loadable up-counter with clear, enable and an expired flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then stream 0xA1,0xB2,0xC3,0xD4 with in_valid held high, against the receiver model.
  - in_ready drops after the 4th byte.
  - The receiver captures A1,B2,C3,D4 in order.
  - done pulses exactly once, 16 cycles after the first req↑.
  - busy is high for those 16 cycles.
- Insert in_valid gaps of 0–3 cycles between bytes 0x01..0x04.
  - Transmission starts only after the 4th accepted byte.
  - Byte order is preserved.
- Tie ack=0, then fill the buffer.
  - req stays high for 15 cycles.
  - err pulses once, req=0.
  - Return to FILL with in_ready=1; no done.
- Hold ack=1 permanently after the first req.
  - Enter WAIT_ACK_LOW, then err after 15 cycles.
  - tx_idx never advances.
- Assert rst for 1 cycle during byte 2 of a burst.
  - req=0 and busy=0 at the next edge.
  - No done/err; a fresh 4-byte burst then completes normally.
- Run two back-to-back bursts (0x10..0x13, then 0x20..0x23).
  - Two done pulses; receiver sees all 8 bytes in order.
  - req is never high while ack is high from the previous byte.

Source files
------------

// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared types and constants for the 4-phase req/ack byte link
package link_pkg;

    localparam int LINK_DW        = 8;
    localparam int LINK_NUM_BYTES = 4;

    typedef enum logic [2:0] {
        FILL,
        SEND_REQ,
        WAIT_ACK_LOW,
        DONE,
        ERROR
    } master_state_e;

endpackage

// File: rtl/link_timeout.sv
// rtl/link_timeout.sv - loadable up-counter with clear/enable; expired flags the last allowed wait cycle
module link_timeout #(
    parameter int TIMEOUT_CYCLES = 15,
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The edge that would bring the count to TIMEOUT_CYCLES is the abort edge.
    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/link_master.sv
// rtl/link_master.sv - buffers a burst from a valid/ready source and sends it over the 4-phase link
module link_master
    import link_pkg::*;
#(
    parameter int NUM_BYTES      = LINK_NUM_BYTES,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [LINK_DW-1:0] in_data,
    output logic               in_ready,
    output logic               req,
    input  logic               ack,
    output logic [LINK_DW-1:0] data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int IDX_W = $clog2(NUM_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    master_state_e      state_q, state_d;
    logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
    logic [LINK_DW-1:0] buf_q [NUM_BYTES];
    logic [LINK_DW-1:0] buf_d [NUM_BYTES];
    logic               tmo_clr;
    logic               tmo_en;
    logic               tmo_expired;

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        tx_idx_d = tx_idx_q;
        buf_d    = buf_q;
        tmo_en   = 1'b0;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    buf_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        tx_idx_d = '0;
                        state_d  = SEND_REQ;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            SEND_REQ: begin
                tmo_en = !ack;
                // ack is checked first so a late ack still beats the timeout
                if (ack) begin
                    state_d = WAIT_ACK_LOW;
                end else if (tmo_expired) begin
                    state_d = ERROR;
                end
            end
            WAIT_ACK_LOW: begin
                tmo_en = ack;
                if (!ack) begin
                    if (tx_idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                        state_d  = SEND_REQ;
                    end
                end else if (tmo_expired) begin
                    state_d = ERROR;
                end
            end
            DONE: begin
                state_d = FILL;
            end
            ERROR: begin
                wr_idx_d = '0;
                state_d  = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Every handshake phase gets a fresh budget, since each phase is a state change.
    assign tmo_clr = (state_d != state_q);

    link_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .load    (1'b0),
        .load_val({TMO_W{1'b0}}),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            tx_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            tx_idx_q <= tx_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        in_ready = (state_q == FILL);
        req      = (state_q == SEND_REQ);
        busy     = (state_q == SEND_REQ) || (state_q == WAIT_ACK_LOW);
        done     = (state_q == DONE);
        err      = (state_q == ERROR);
        data     = busy ? buf_q[tx_idx_q] : '0;
    end

endmodule

// File: tb/tb_link_master.sv
// tb/tb_link_master.sv - directed bench for link_master with a 4-phase receiver model
module tb_link_master;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       req;
    logic       ack;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       err;

    logic       ack_sel;
    logic       ack_force;
    logic       rx_ack;
    int         rx_st;
    logic [7:0] rx_log [$];
    logic       req_prev;
    int         rise_viol;

    int checks;
    int errors;

    link_master #(
        .NUM_BYTES(4),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .req     (req),
        .ack     (ack),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receiver: ack rises one cycle after it samples req, falls as soon as req drops.
    always @(posedge clk) begin
        if (rst) begin
            rx_st <= 0;
        end else begin
            case (rx_st)
                0: if (req) rx_st <= 1;
                1: begin
                    rx_st <= 2;
                    rx_log.push_back(data);
                end
                default: if (!req) rx_st <= 0;
            endcase
        end
    end
    assign rx_ack = (rx_st == 2) && req;
    assign ack    = ack_sel ? ack_force : rx_ack;

    initial begin
        req_prev  = 1'b0;
        rise_viol = 0;
    end
    always @(negedge clk) begin
        if (req && !req_prev && ack) rise_viol <= rise_viol + 1;
        req_prev <= req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
    endtask

    task automatic watch(input int limit, output int n_done, output int n_err, output int n_busy,
                         output int n_req, output int t_done, output int t_err, output int n_dchg);
        logic [7:0] d0;
        int stop;
        n_done = 0; n_err = 0; n_busy = 0; n_req = 0; n_dchg = 0;
        t_done = -1; t_err = -1;
        d0 = data;
        stop = limit;
        for (int k = 0; k < stop; k++) begin
            if (k > 0) @(negedge clk);
            if (req) n_req++;
            if (busy) begin
                n_busy++;
                if (data !== d0) n_dchg++;
            end
            if (done) begin
                n_done++;
                if (t_done < 0) begin
                    t_done = k;
                    stop = k + 3;
                end
            end
            if (err) begin
                n_err++;
                if (t_err < 0) begin
                    t_err = k;
                    stop = k + 3;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1);
    end

    initial begin
        int nd, ne, nb, nr, td, te, dc;
        int base, v0;
        logic [7:0] exp_b [8];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        ack_sel = 1'b0;
        ack_force = 1'b0;

        // Reset state, then a plain burst with in_valid held high throughout
        do_reset();
        check("rst_req", 32'(req), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_data", 32'(data), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        base = rx_log.size();
        push(8'hA1, 0); push(8'hB2, 0); push(8'hC3, 0); push(8'hD4, 0);
        in_data = 8'hEE;
        check("b1_in_ready_low", 32'(in_ready), 0);
        check("b1_req_first", 32'(req), 1);
        watch(40, nd, ne, nb, nr, td, te, dc);
        in_valid = 1'b0;
        check("b1_done_cnt", nd, 1);
        check("b1_done_time", td, 16);
        check("b1_busy_cycles", nb, 16);
        check("b1_req_cycles", nr, 12);
        check("b1_err_cnt", ne, 0);
        check("b1_rx_cnt", rx_log.size() - base, 4);
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
        for (int i = 0; i < 4; i++)
            if (base + i < rx_log.size()) check("b1_rx_byte", 32'(rx_log[base + i]), 32'(exp_b[i]));

        // Gapped input: nothing leaves before the 4th byte
        do_reset();
        base = rx_log.size();
        for (int i = 0; i < 4; i++) begin
            push(8'(i + 1), i);
            if (i < 3) check("gap_no_early_req", 32'(req | busy), 0);
        end
        in_valid = 1'b0;
        check("gap_req_start", 32'(req), 1);
        watch(40, nd, ne, nb, nr, td, te, dc);
        check("gap_done_time", td, 16);
        check("gap_rx_cnt", rx_log.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < rx_log.size()) check("gap_rx_byte", 32'(rx_log[base + i]), i + 1);

        // ack stuck low: timeout while requesting
        do_reset();
        ack_sel = 1'b1;
        ack_force = 1'b0;
        push(8'h11, 0); push(8'h22, 0); push(8'h33, 0); push(8'h44, 0);
        in_valid = 1'b0;
        watch(60, nd, ne, nb, nr, td, te, dc);
        check("tmo_req_cycles", nr, 15);
        check("tmo_err_time", td < 0 ? te : -2, 15);
        check("tmo_err_cnt", ne, 1);
        check("tmo_done_cnt", nd, 0);
        check("tmo_back_in_ready", 32'(in_ready), 1);
        check("tmo_back_req", 32'(req), 0);

        // ack stuck high after the first req: timeout while waiting for ack to fall
        do_reset();
        ack_force = 1'b0;
        push(8'h5A, 0); push(8'h6B, 0); push(8'h7C, 0); push(8'h8D, 0);
        in_valid = 1'b0;
        ack_force = 1'b1;
        check("hold_data0", 32'(data), 32'h5A);
        watch(60, nd, ne, nb, nr, td, te, dc);
        check("hold_err_time", te, 16);
        check("hold_req_cycles", nr, 1);
        check("hold_data_stable", dc, 0);
        check("hold_done_cnt", nd, 0);
        ack_sel = 1'b0;
        ack_force = 1'b0;

        // Reset during the second byte, then a clean burst
        do_reset();
        push(8'h41, 0); push(8'h42, 0); push(8'h43, 0); push(8'h44, 0);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(busy), 1);
        check("mid_data_byte2", 32'(data), 32'h42);
        rst = 1'b1;
        @(negedge clk);
        check("mid_req_after", 32'(req), 0);
        check("mid_busy_after", 32'(busy), 0);
        check("mid_in_ready_after", 32'(in_ready), 1);
        rst = 1'b0;
        watch(20, nd, ne, nb, nr, td, te, dc);
        check("mid_no_done", nd, 0);
        check("mid_no_err", ne, 0);
        base = rx_log.size();
        push(8'h31, 0); push(8'h32, 0); push(8'h33, 0); push(8'h34, 0);
        in_valid = 1'b0;
        watch(40, nd, ne, nb, nr, td, te, dc);
        check("mid_fresh_done_time", td, 16);
        check("mid_fresh_rx_cnt", rx_log.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < rx_log.size()) check("mid_fresh_rx_byte", 32'(rx_log[base + i]), 32'h31 + i);

        // Back-to-back bursts
        do_reset();
        base = rx_log.size();
        v0 = rise_viol;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 0);
        in_valid = 1'b0;
        watch(40, nd, ne, nb, nr, td, te, dc);
        check("b2b_done1", nd, 1);
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 0);
        in_valid = 1'b0;
        watch(40, nd, ne, nb, nr, td, te, dc);
        check("b2b_done2", nd, 1);
        check("b2b_done2_time", td, 16);
        check("b2b_rx_cnt", rx_log.size() - base, 8);
        for (int i = 0; i < 8; i++) exp_b[i] = (i < 4) ? 8'h10 + 8'(i) : 8'h20 + 8'(i - 4);
        for (int i = 0; i < 8; i++)
            if (base + i < rx_log.size()) check("b2b_rx_byte", 32'(rx_log[base + i]), 32'(exp_b[i]));
        check("b2b_req_vs_ack", rise_viol - v0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
